// File: rtl/capture_writer_if.sv
// Word stream into the capture writer and the sample-memory write port out of it.
interface capture_writer_if #(
   parameter int ADDR_W = 10
) ();
   logic [255:0]      wr_states;
   logic              word_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [255:0]      mem_wdata;

   modport master (
      output wr_states, word_valid,
      input  mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  wr_states, word_valid,
      output mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/capture_writer.sv
// Ring-buffer capture writer: pre-trigger fill, mask/value trigger on 8 sample
// slots, post-trigger fill, then stop and report where the trigger landed.
module capture_writer #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   capture_writer_if.slave   bus,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic              force_trig_i,
   input  logic [31:0]       trig_mask_i,
   input  logic [31:0]       trig_value_i,
   input  logic [ADDR_W-1:0] pre_count_i,
   input  logic [ADDR_W-1:0] post_count_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] trig_addr_o,
   output logic [2:0]        trig_slot_o,
   output logic [ADDR_W-1:0] start_addr_o
);
   typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_WAIT, ST_POST, ST_DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
   logic              force_q, force_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [255:0]      mem_wdata_q, mem_wdata_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;
   logic [2:0]        trig_slot_q, trig_slot_d;

   logic [7:0]        slot_match;
   logic [2:0]        hit_slot;
   logic              capturing;
   logic              accept;
   logic              trig_hit;

   // Slot j gathers bit j of every channel byte into one 32-bit channel vector.
   for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      logic [31:0] slot_bits;
      for (genvar ci = 0; ci < 32; ci++) begin : g_chan
         assign slot_bits[ci] = bus.wr_states[8*ci + gi];
      end
      assign slot_match[gi] = ((slot_bits ^ trig_value_i) & trig_mask_i) == 32'd0;
   end

   // Oldest matching slot wins; 7 is also the answer for a force-only trigger.
   always_comb begin
      hit_slot = 3'd7;
      for (int j = 0; j < 8; j++) begin
         if (slot_match[j]) hit_slot = 3'(j);
      end
   end

   assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
   assign accept    = bus.word_valid && capturing;
   assign trig_hit  = (|slot_match) || force_q || force_trig_i;

   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      pre_cnt_d    = pre_cnt_q;
      post_cnt_d   = post_cnt_q;
      force_d      = force_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      trig_addr_d  = trig_addr_q;
      trig_slot_d  = trig_slot_q;
      start_addr_d = start_addr_q;

      if (abort_i) begin
         state_d = ST_IDLE;
         force_d = 1'b0;
      end else if (arm_i && !capturing) begin
         wp_d         = '0;
         pre_cnt_d    = '0;
         post_cnt_d   = '0;
         force_d      = 1'b0;
         trig_addr_d  = '0;
         trig_slot_d  = '0;
         start_addr_d = '0;
         state_d      = (pre_count_i == '0) ? ST_WAIT : ST_PRE;
      end else begin
         if (force_trig_i && capturing) force_d = 1'b1;
         if (accept) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wp_q;
            mem_wdata_d = bus.wr_states;
            wp_d        = wp_q + 1'b1;
            case (state_q)
               ST_PRE: begin
                  pre_cnt_d = pre_cnt_q + 1'b1;
                  if (pre_cnt_d == pre_count_i) state_d = ST_WAIT;
               end
               ST_WAIT: begin
                  if (trig_hit) begin
                     trig_addr_d  = wp_q;
                     trig_slot_d  = hit_slot;
                     start_addr_d = wp_q - pre_count_i;
                     force_d      = 1'b0;
                     state_d      = (post_count_i == '0) ? ST_DONE : ST_POST;
                  end
               end
               ST_POST: begin
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (post_cnt_d == post_count_i) state_d = ST_DONE;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wp_q         <= '0;
         pre_cnt_q    <= '0;
         post_cnt_q   <= '0;
         force_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         trig_addr_q  <= '0;
         trig_slot_q  <= '0;
         start_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         wp_q         <= wp_d;
         pre_cnt_q    <= pre_cnt_d;
         post_cnt_q   <= post_cnt_d;
         force_q      <= force_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         trig_addr_q  <= trig_addr_d;
         trig_slot_q  <= trig_slot_d;
         start_addr_q <= start_addr_d;
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign busy_o        = capturing;
   assign done_o        = (state_q == ST_DONE);
   assign trig_addr_o   = trig_addr_q;
   assign trig_slot_o   = trig_slot_q;
   assign start_addr_o  = start_addr_q;
endmodule

// File: tb/tb_capture_writer.sv
// Bench for capture_writer: two instances (1024-word and 16-word rings) driven
// with the same stimulus and checked against a word-level capture model.
module tb_capture_writer;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] wr_states = '0;
   logic         word_valid = 1'b0;
   logic         arm = 1'b0;
   logic         abort = 1'b0;
   logic         force_trig = 1'b0;
   logic [31:0]  trig_mask = '0;
   logic [31:0]  trig_value = '0;
   logic [9:0]   pre_cnt = '0;
   logic [9:0]   post_cnt = '0;

   always #5 clk = ~clk;

   capture_writer_if #(.ADDR_W(10)) bus_a ();
   capture_writer_if #(.ADDR_W(4))  bus_b ();
   assign bus_a.wr_states  = wr_states;
   assign bus_a.word_valid = word_valid;
   assign bus_b.wr_states  = wr_states;
   assign bus_b.word_valid = word_valid;

   logic       busy_a, done_a, busy_b, done_b;
   logic [9:0] taddr_a, saddr_a;
   logic [3:0] taddr_b, saddr_b;
   logic [2:0] tslot_a, tslot_b;

   capture_writer #(.ADDR_W(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a),
      .arm_i(arm), .abort_i(abort), .force_trig_i(force_trig),
      .trig_mask_i(trig_mask), .trig_value_i(trig_value),
      .pre_count_i(pre_cnt), .post_count_i(post_cnt),
      .busy_o(busy_a), .done_o(done_a), .trig_addr_o(taddr_a),
      .trig_slot_o(tslot_a), .start_addr_o(saddr_a)
   );

   capture_writer #(.ADDR_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b),
      .arm_i(arm), .abort_i(abort), .force_trig_i(force_trig),
      .trig_mask_i(trig_mask), .trig_value_i(trig_value),
      .pre_count_i(pre_cnt[3:0]), .post_count_i(post_cnt[3:0]),
      .busy_o(busy_b), .done_o(done_b), .trig_addr_o(taddr_b),
      .trig_slot_o(tslot_b), .start_addr_o(saddr_b)
   );

   // Uniform views of both instances, index 0 = 1024-word ring, 1 = 16-word ring.
   logic         busy_v[2], done_v[2], we_v[2];
   logic [9:0]   taddr_v[2], saddr_v[2], maddr_v[2];
   logic [2:0]   tslot_v[2];
   logic [255:0] mdata_v[2];
   assign busy_v[0]  = busy_a;             assign busy_v[1]  = busy_b;
   assign done_v[0]  = done_a;             assign done_v[1]  = done_b;
   assign we_v[0]    = bus_a.mem_we;       assign we_v[1]    = bus_b.mem_we;
   assign taddr_v[0] = taddr_a;            assign taddr_v[1] = {6'd0, taddr_b};
   assign saddr_v[0] = saddr_a;            assign saddr_v[1] = {6'd0, saddr_b};
   assign maddr_v[0] = bus_a.mem_addr;     assign maddr_v[1] = {6'd0, bus_b.mem_addr};
   assign tslot_v[0] = tslot_a;            assign tslot_v[1] = tslot_b;
   assign mdata_v[0] = bus_a.mem_wdata;    assign mdata_v[1] = bus_b.mem_wdata;

   typedef struct packed {
      logic         done;
      logic [9:0]   addr;
      logic [255:0] data;
   } wr_t;

   wr_t          wr_qa[$];
   wr_t          wr_qb[$];
   logic [255:0] stim_q[$];
   int           base_a, base_b;
   int           checks = 0;
   int           errors = 0;

   // Memory-side monitor: every cycle with a write enable becomes one record.
   always @(negedge clk) begin
      if (bus_a.mem_we) wr_qa.push_back({done_a, bus_a.mem_addr, bus_a.mem_wdata});
      if (bus_b.mem_we) wr_qb.push_back({done_b, 6'd0, bus_b.mem_addr, bus_b.mem_wdata});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand_word();
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   // Oldest matching slot index, or -1 when no slot of the word matches.
   function automatic int model_slot(input logic [255:0] w, input logic [31:0] m, input logic [31:0] v);
      int          best;
      logic [31:0] s;
      best = -1;
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 32; i++) s[i] = w[8*i + j];
         if (((s ^ v) & m) == 32'd0) best = j;
      end
      return best;
   endfunction

   // Arms a capture, feeds stim_q, then compares both instances with the model:
   // the trigger is the first word at index >= pre that matches (or any such word
   // once force is pending), and capture ends pre-free after post more words.
   task automatic run_scenario(input string name, input int pre, input int post,
                               input logic [31:0] m, input logic [31:0] v,
                               input bit frc, input bit gaps);
      int  n, t, slot, hit, n_exp, nw, amask;
      bit  done_exp;
      wr_t e;
      trig_mask = m;  trig_value = v;
      pre_cnt = 10'(pre);  post_cnt = 10'(post);
      abort = 1'b1; tick(); abort = 1'b0;
      arm = 1'b1;   tick(); arm = 1'b0;
      base_a = wr_qa.size();
      base_b = wr_qb.size();
      if (frc) begin
         force_trig = 1'b1; tick(); force_trig = 1'b0;
      end
      foreach (stim_q[k]) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         wr_states = stim_q[k]; word_valid = 1'b1; tick(); word_valid = 1'b0;
      end
      repeat (3) tick();

      n = stim_q.size(); t = -1; slot = 7;
      for (int k = 0; k < n; k++) begin
         if (t < 0 && k >= pre) begin
            hit = model_slot(stim_q[k], m, v);
            if (hit >= 0 || frc) begin
               t = k;
               slot = (hit >= 0) ? hit : 7;
            end
         end
      end
      done_exp = (t >= 0) && (t + post + 1 <= n);
      n_exp    = done_exp ? t + post + 1 : n;
      $display("scenario %s: words=%0d pre=%0d post=%0d trigger_word=%0d writes=%0d/%0d",
               name, n, pre, post, t, wr_qa.size() - base_a, n_exp);

      for (int d = 0; d < 2; d++) begin
         amask = (d == 0) ? 1023 : 15;
         nw = (d == 0) ? wr_qa.size() - base_a : wr_qb.size() - base_b;
         checks++;
         if (nw != n_exp) begin
            errors++;
            $display("FAIL %s write_count dut%0d got %0d want %0d", name, d, nw, n_exp);
         end
         for (int k = 0; k < nw && k < n_exp; k++) begin
            e = (d == 0) ? wr_qa[base_a + k] : wr_qb[base_b + k];
            checks++;
            if (e.addr !== 10'(k & amask) || e.data !== stim_q[k] ||
                e.done !== (done_exp && k == n_exp - 1)) begin
               errors++;
               $display("FAIL %s write%0d dut%0d got addr=%0d done=%0b data=%h want addr=%0d done=%0b data=%h",
                        name, k, d, e.addr, e.done, e.data[31:0], k & amask,
                        done_exp && k == n_exp - 1, stim_q[k][31:0]);
            end
         end
         checks++;
         if (done_v[d] !== done_exp || busy_v[d] !== !done_exp) begin
            errors++;
            $display("FAIL %s status dut%0d got done=%0b busy=%0b want done=%0b busy=%0b",
                     name, d, done_v[d], busy_v[d], done_exp, !done_exp);
         end
         if (t >= 0) begin
            checks++;
            if (taddr_v[d] !== 10'(t & amask) || tslot_v[d] !== 3'(slot) ||
                saddr_v[d] !== 10'((t - pre) & amask)) begin
               errors++;
               $display("FAIL %s trig_info dut%0d got addr=%0d slot=%0d start=%0d want addr=%0d slot=%0d start=%0d",
                        name, d, taddr_v[d], tslot_v[d], saddr_v[d], t & amask, slot, (t - pre) & amask);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (we_v[d] !== 1'b0 || maddr_v[d] !== '0 || mdata_v[d] !== '0 || busy_v[d] !== 1'b0 ||
             done_v[d] !== 1'b0 || taddr_v[d] !== '0 || tslot_v[d] !== '0 || saddr_v[d] !== '0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d got we=%0b addr=%0d busy=%0b done=%0b taddr=%0d want all zero",
                     d, we_v[d], maddr_v[d], busy_v[d], done_v[d], taddr_v[d]);
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [255:0] w;
      stim_q.delete();
      for (int k = 0; k < 10; k++) begin
         w = rand_word();
         w[7:0] = (k == 6) ? 8'h01 : 8'h00;
         stim_q.push_back(w);
      end
      run_scenario("basic", 4, 3, 32'h1, 32'h1, 1'b0, 1'b0);
      checks++;
      if (taddr_a !== 10'd6 || tslot_a !== 3'd0 || saddr_a !== 10'd2 || done_a !== 1'b1) begin
         errors++;
         $display("FAIL basic_trigger got taddr=%0d slot=%0d start=%0d done=%0b want 6 0 2 1",
                  taddr_a, tslot_a, saddr_a, done_a);
      end
   endtask

   task automatic test_pre_blind();
      logic [255:0] w;
      stim_q.delete();
      for (int k = 0; k < 8; k++) begin
         w = rand_word();
         w[7:0] = 8'h01;
         stim_q.push_back(w);
      end
      run_scenario("pre_blind", 4, 2, 32'h1, 32'h1, 1'b0, 1'b1);
      checks++;
      if (taddr_a !== 10'd4) begin
         errors++;
         $display("FAIL pre_blind_taddr got %0d want 4", taddr_a);
      end
   endtask

   task automatic test_wrap();
      logic [255:0] w;
      wr_t          e;
      stim_q.delete();
      for (int k = 0; k < 25; k++) begin
         w = rand_word();
         w[7:0] = (k == 20) ? 8'h01 : 8'h00;
         stim_q.push_back(w);
      end
      run_scenario("wrap", 2, 2, 32'h1, 32'h1, 1'b0, 1'b0);
      e = wr_qb[wr_qb.size() - 1];
      checks++;
      if (taddr_b !== 4'd4 || saddr_b !== 4'd2 || e.addr !== 10'd6 || taddr_a !== 10'd20) begin
         errors++;
         $display("FAIL wrap_addrs got taddr16=%0d start16=%0d last16=%0d taddr1024=%0d want 4 2 6 20",
                  taddr_b, saddr_b, e.addr, taddr_a);
      end
   endtask

   task automatic test_slot_priority();
      logic [255:0] w;
      stim_q.delete();
      for (int k = 0; k < 3; k++) begin
         w = rand_word();
         w[31:24] = (k == 2) ? 8'h24 : 8'h00;
         stim_q.push_back(w);
      end
      run_scenario("slot_priority", 1, 1, 32'h8, 32'h8, 1'b0, 1'b0);
      checks++;
      if (tslot_a !== 3'd5 || tslot_b !== 3'd5) begin
         errors++;
         $display("FAIL slot_priority got %0d/%0d want 5", tslot_a, tslot_b);
      end
   endtask

   task automatic test_force_zero();
      stim_q.delete();
      stim_q.push_back(rand_word());
      stim_q.push_back(rand_word());
      run_scenario("force_zero", 0, 0, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b1, 1'b0);
      checks++;
      if (taddr_a !== 10'd0 || tslot_a !== 3'd7 || done_a !== 1'b1 || wr_qa.size() - base_a != 1) begin
         errors++;
         $display("FAIL force_zero got taddr=%0d slot=%0d done=%0b writes=%0d want 0 7 1 1",
                  taddr_a, tslot_a, done_a, wr_qa.size() - base_a);
      end
   endtask

   task automatic test_abort();
      int nw;
      trig_mask = 32'h0; trig_value = 32'h0; pre_cnt = 10'd1; post_cnt = 10'd5;
      abort = 1'b1; tick(); abort = 1'b0;
      arm = 1'b1;   tick(); arm = 1'b0;
      base_a = wr_qa.size();
      base_b = wr_qb.size();
      for (int k = 0; k < 3; k++) begin
         wr_states = rand_word(); word_valid = 1'b1; tick(); word_valid = 1'b0;
      end
      wr_states = rand_word(); word_valid = 1'b1; abort = 1'b1;
      tick();
      word_valid = 1'b0; abort = 1'b0;
      repeat (2) tick();
      $display("scenario abort_in_post: writes=%0d busy=%0b", wr_qa.size() - base_a, busy_a);
      for (int d = 0; d < 2; d++) begin
         nw = (d == 0) ? wr_qa.size() - base_a : wr_qb.size() - base_b;
         checks++;
         if (nw != 3 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_post dut%0d got writes=%0d busy=%0b done=%0b want 3 0 0",
                     d, nw, busy_v[d], done_v[d]);
         end
      end
      stim_q.delete();
      stim_q.push_back(rand_word());
      run_scenario("rearm_after_abort", 0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      trig_mask = 32'hFFFF_FFFF; trig_value = 32'h5A5A_5A5A; pre_cnt = 10'd0; post_cnt = 10'd0;
      abort = 1'b1; tick(); abort = 1'b0;
      arm = 1'b1;   tick(); arm = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wr_states = rand_word(); word_valid = 1'b1; tick();
      end
      #2 rst_n = 1'b0;
      #1;
      $display("scenario reset_mid_wait: rst_n asserted with write in flight");
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (we_v[d] !== 1'b0 || maddr_v[d] !== '0 || mdata_v[d] !== '0 || busy_v[d] !== 1'b0 ||
             done_v[d] !== 1'b0 || taddr_v[d] !== '0 || tslot_v[d] !== '0 || saddr_v[d] !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait dut%0d got we=%0b addr=%0d busy=%0b done=%0b want all zero",
                     d, we_v[d], maddr_v[d], busy_v[d], done_v[d]);
         end
      end
      word_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      stim_q.delete();
      stim_q.push_back(rand_word());
      run_scenario("rearm_after_reset", 0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      stim_q.delete();
      for (int k = 0; k < 16; k++) stim_q.push_back(rand_word());
      run_scenario("back_to_back", 5, 8, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] m;
      int          n;
      for (int it = 0; it < 8; it++) begin
         m = '0;
         repeat ($urandom_range(4, 8)) m[$urandom_range(0, 31)] = 1'b1;
         n = $urandom_range(4, 20);
         stim_q.delete();
         for (int k = 0; k < n; k++) stim_q.push_back(rand_word());
         run_scenario($sformatf("random%0d", it), $urandom_range(0, 5), $urandom_range(0, 5),
                      m, $urandom, ($urandom_range(0, 3) == 0), (it % 2 == 1));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pre_blind();
      test_wrap();
      test_slot_priority();
      test_force_zero();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
